// File: rtl/multi_issue_decode_queue_pkg.sv
// multi_issue_decode_queue_pkg: shared operation encoding and bundle classification helpers
package multi_issue_decode_queue_pkg;
  localparam int DELAY_SLOT = 1;
  typedef enum logic [5:0] {
    OP_INVALID = 6'd0, OP_NOP, OP_SLL, OP_SRL, OP_SRA, OP_ADDU, OP_SUBU, OP_AND, OP_OR, OP_XOR,
    OP_NOR, OP_SLT, OP_SLTU, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI, OP_LUI,
    OP_LB, OP_LW, OP_SB, OP_SW, OP_J, OP_JAL, OP_JR, OP_JALR, OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ,
    OP_BLTZ, OP_BGEZ, OP_BLTZAL, OP_BGEZAL, OP_SYSCALL, OP_BREAK, OP_ERET, OP_MTC0, OP_MFC0,
    OP_TLBR, OP_TLBWI, OP_TLBWR, OP_TLBP, OP_CACHE
  } operation_t;
  function automatic logic is_branch(operation_t op);
    return op inside {OP_J, OP_JAL, OP_JR, OP_JALR, OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ,
                      OP_BLTZ, OP_BGEZ, OP_BLTZAL, OP_BGEZAL};
  endfunction
  function automatic logic is_serial(operation_t op);
    return op inside {OP_SYSCALL, OP_BREAK, OP_ERET, OP_MTC0, OP_MFC0,
                      OP_TLBR, OP_TLBWI, OP_TLBWR, OP_TLBP, OP_CACHE};
  endfunction
endpackage

// File: rtl/multi_issue_decode_queue_if.sv
// multi_issue_decode_queue_if: fetch-side and issue-side handshake bundle
interface multi_issue_decode_queue_if #(
  parameter int FETCH_WIDTH  = 2,
  parameter int DECODE_WIDTH = 2
);
  import multi_issue_decode_queue_pkg::*;
  logic                                 in_valid;
  logic                                 in_ready;
  logic [$clog2(FETCH_WIDTH+1)-1:0]     in_count;
  logic [31:0]                          in_pc;
  logic [FETCH_WIDTH*32-1:0]            in_inst;
  logic [DECODE_WIDTH-1:0]              out_valid;
  logic                                 out_ready;
  operation_t [DECODE_WIDTH-1:0]        out_operation;
  logic [DECODE_WIDTH*32-1:0]           out_pc;
  logic [DECODE_WIDTH*32-1:0]           out_inst;
  modport master (
    output in_valid, in_count, in_pc, in_inst, out_ready,
    input  in_ready, out_valid, out_operation, out_pc, out_inst
  );
  modport slave (
    input  in_valid, in_count, in_pc, in_inst, out_ready,
    output in_ready, out_valid, out_operation, out_pc, out_inst
  );
endinterface

// File: rtl/multi_issue_decode_queue_inst_decoder.sv
// multi_issue_decode_queue_inst_decoder: classifies one raw MIPS word into an operation_t
module multi_issue_decode_queue_inst_decoder
  import multi_issue_decode_queue_pkg::*;
(
  input  logic        valid,
  input  logic [31:0] inst,
  output operation_t  op
);
  logic [5:0] opc, fn;
  logic [4:0] rs, rt;
  assign opc = inst[31:26];
  assign fn  = inst[5:0];
  assign rs  = inst[25:21];
  assign rt  = inst[20:16];
  // Map the word to its operation; absent lanes and unknown encodings stay OP_INVALID
  always_comb begin
    op = OP_INVALID;
    if (valid)
      case (opc)
        6'h00:
          case (fn)
            6'h00: op = (inst == 32'd0) ? OP_NOP : OP_SLL;
            6'h02: op = OP_SRL;
            6'h03: op = OP_SRA;
            6'h08: op = OP_JR;
            6'h09: op = OP_JALR;
            6'h0c: op = OP_SYSCALL;
            6'h0d: op = OP_BREAK;
            6'h21: op = OP_ADDU;
            6'h23: op = OP_SUBU;
            6'h24: op = OP_AND;
            6'h25: op = OP_OR;
            6'h26: op = OP_XOR;
            6'h27: op = OP_NOR;
            6'h2a: op = OP_SLT;
            6'h2b: op = OP_SLTU;
            default: ;
          endcase
        6'h01:
          case (rt)
            5'h00: op = OP_BLTZ;
            5'h01: op = OP_BGEZ;
            5'h10: op = OP_BLTZAL;
            5'h11: op = OP_BGEZAL;
            default: ;
          endcase
        6'h02: op = OP_J;
        6'h03: op = OP_JAL;
        6'h04: op = OP_BEQ;
        6'h05: op = OP_BNE;
        6'h06: op = OP_BLEZ;
        6'h07: op = OP_BGTZ;
        6'h09: op = OP_ADDIU;
        6'h0a: op = OP_SLTI;
        6'h0b: op = OP_SLTIU;
        6'h0c: op = OP_ANDI;
        6'h0d: op = OP_ORI;
        6'h0e: op = OP_XORI;
        6'h0f: op = OP_LUI;
        6'h10:
          if (inst[25])
            case (fn)
              6'h01: op = OP_TLBR;
              6'h02: op = OP_TLBWI;
              6'h06: op = OP_TLBWR;
              6'h08: op = OP_TLBP;
              6'h18: op = OP_ERET;
              default: ;
            endcase
          else
            op = (rs == 5'h00) ? OP_MFC0 : (rs == 5'h04) ? OP_MTC0 : OP_INVALID;
        6'h20: op = OP_LB;
        6'h23: op = OP_LW;
        6'h28: op = OP_SB;
        6'h2b: op = OP_SW;
        6'h2f: op = OP_CACHE;
        default: ;
      endcase
  end
endmodule

// File: rtl/multi_issue_decode_queue.sv
// multi_issue_decode_queue: fetch buffer plus N-wide decode with branch/slot pairing and serial-op isolation
module multi_issue_decode_queue
  import multi_issue_decode_queue_pkg::*;
#(
  parameter int FETCH_WIDTH  = 2,
  parameter int DECODE_WIDTH = 2,
  parameter int DEPTH        = 8
) (
  input logic                    clk,
  input logic                    resetn,
  input logic                    flush,
  multi_issue_decode_queue_if.slave io
);
  localparam int AW  = $clog2(DEPTH);
  localparam int PW  = AW + 1;
  localparam int NW  = $clog2(DECODE_WIDTH + 1);
  localparam int ICW = $clog2(FETCH_WIDTH + 1);
  logic [PW-1:0]                  head_q, head_d, tail_q, tail_d, count_q, count_d;
  logic [31:0]                    pc_q [DEPTH];
  logic [31:0]                    pc_d [DEPTH];
  logic [31:0]                    inst_q [DEPTH];
  logic [31:0]                    inst_d [DEPTH];
  logic [DECODE_WIDTH-1:0]        out_valid_q, out_valid_d;
  operation_t [DECODE_WIDTH-1:0]  out_op_q, out_op_d;
  logic [DECODE_WIDTH-1:0][31:0]  out_pc_q, out_pc_d, out_inst_q, out_inst_d;
  logic [31:0]                    cand_pc [DECODE_WIDTH];
  logic [31:0]                    cand_inst [DECODE_WIDTH];
  operation_t                     cand_op [DECODE_WIDTH];
  logic [DECODE_WIDTH:0]          present;
  logic [DECODE_WIDTH-1:0]        take;
  logic [NW-1:0]                  n;
  logic                           push, load, stop;
  assign io.in_ready      = (PW'(DEPTH) - count_q) >= PW'(FETCH_WIDTH);
  assign io.out_valid     = out_valid_q;
  assign io.out_operation = out_op_q;
  assign io.out_pc        = out_pc_q;
  assign io.out_inst      = out_inst_q;
  assign push = io.in_valid && io.in_ready && !flush;
  assign load = (out_valid_q == '0) || io.out_ready;
  // The extra top bit lets a branch in the last lane see "no slot available"
  assign present[DECODE_WIDTH] = 1'b0;
  for (genvar g = 0; g < DECODE_WIDTH; g++) begin : g_lane
    assign present[g]   = PW'(g) < count_q;
    assign cand_pc[g]   = pc_q[head_q[AW-1:0] + AW'(g)];
    assign cand_inst[g] = inst_q[head_q[AW-1:0] + AW'(g)];
    assign take[g]      = NW'(g) < n;
    multi_issue_decode_queue_inst_decoder u_inst_decoder (
      .valid (present[g]),
      .inst  (cand_inst[g]),
      .op    (cand_op[g])
    );
  end
  // Bundle size: stop at a serial op (alone only at lane 0) or a branch whose slot does not fit
  always_comb begin
    n = '0;
    stop = 1'b0;
    for (int i = 0; i < DECODE_WIDTH; i++) begin
      if (!stop) begin
        if (!present[i]) stop = 1'b1;
        else if (is_serial(cand_op[i])) begin
          n = (i == 0) ? NW'(1) : n;
          stop = 1'b1;
        end else if (is_branch(cand_op[i])) begin
          n = (i + DELAY_SLOT < DECODE_WIDTH && present[i+DELAY_SLOT]) ? NW'(i + DELAY_SLOT + 1) : n;
          stop = 1'b1;
        end else n = NW'(i + 1);
      end
    end
  end
  // Next state: enqueue the beat, advance pointers, refill or hold the output bundle; flush wins
  always_comb begin
    pc_d = pc_q;
    inst_d = inst_q;
    for (int j = 0; j < FETCH_WIDTH; j++) begin
      if (push && ICW'(j) < io.in_count) begin
        pc_d[tail_q[AW-1:0] + AW'(j)] = io.in_pc + 32'(4 * j);
        inst_d[tail_q[AW-1:0] + AW'(j)] = io.in_inst[j*32 +: 32];
      end
    end
    tail_d = flush ? '0 : push ? tail_q + PW'(io.in_count) : tail_q;
    head_d = flush ? '0 : load ? head_q + PW'(n) : head_q;
    count_d = flush ? '0 : count_q + (push ? PW'(io.in_count) : '0) - (load ? PW'(n) : '0);
    for (int i = 0; i < DECODE_WIDTH; i++) begin
      out_valid_d[i] = flush ? 1'b0 : load ? take[i] : out_valid_q[i];
      out_op_d[i] = (flush || (load && !take[i])) ? OP_INVALID : load ? cand_op[i] : out_op_q[i];
      out_pc_d[i] = (flush || (load && !take[i])) ? 32'd0 : load ? cand_pc[i] : out_pc_q[i];
      out_inst_d[i] = (flush || (load && !take[i])) ? 32'd0 : load ? cand_inst[i] : out_inst_q[i];
    end
  end
  // State registers with asynchronous clear
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      head_q <= '0;
      tail_q <= '0;
      count_q <= '0;
      out_valid_q <= '0;
      out_pc_q <= '0;
      out_inst_q <= '0;
      for (int k = 0; k < DECODE_WIDTH; k++) out_op_q[k] <= OP_INVALID;
      for (int k = 0; k < DEPTH; k++) begin
        pc_q[k] <= '0;
        inst_q[k] <= '0;
      end
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      count_q <= count_d;
      out_valid_q <= out_valid_d;
      out_op_q <= out_op_d;
      out_pc_q <= out_pc_d;
      out_inst_q <= out_inst_d;
      pc_q <= pc_d;
      inst_q <= inst_d;
    end
  end
endmodule

// File: tb/tb_multi_issue_decode_queue.sv
// tb_multi_issue_decode_queue: directed vector table plus hand-written multi-cycle sequences
module tb_multi_issue_decode_queue;
  import multi_issue_decode_queue_pkg::*;
  localparam logic [31:0] I_ADDU = 32'h00221821, I_ORI = 32'h34240055, I_BEQ = 32'h10220004;
  localparam logic [31:0] I_NOP = 32'h00000000, I_SW = 32'hAC220000, I_LW = 32'h8C220000;
  localparam logic [31:0] I_SYSCALL = 32'h0000000C, I_ERET = 32'h42000018, I_JR = 32'h03E00008;
  localparam logic [31:0] I_MFC0 = 32'h40026000, I_BGEZAL = 32'h04310002, I_ADDIU = 32'h24020000;
  localparam logic [31:0] I_LUI = 32'h3C051234, I_J = 32'h08000100, I_TLBP = 32'h42000008;
  localparam logic [31:0] I_JAL = 32'h0C000200, I_SUBU = 32'h00221823, I_CACHE = 32'hBC220000;
  localparam logic [31:0] I_BAD = 32'hFFFFFFFF;
  typedef struct {
    logic [31:0] pc, i0, i1;
    int          cnt;
    logic [1:0]  v;
    operation_t  o0, o1;
  } vec_t;
  localparam int NV = 13;
  vec_t vt [NV];
  logic clk = 1'b0, resetn = 1'b0, flush = 1'b0;
  int pass_cnt = 0, total_cnt = 0, beats;
  multi_issue_decode_queue_if #(.FETCH_WIDTH(2), .DECODE_WIDTH(2)) bus ();
  multi_issue_decode_queue #(.FETCH_WIDTH(2), .DECODE_WIDTH(2), .DEPTH(8)) dut (
    .clk(clk), .resetn(resetn), .flush(flush), .io(bus.slave)
  );
  always #5 clk = ~clk;
  always @(posedge clk)
    if (resetn && bus.in_valid)
      assert (bus.in_count >= 2'd1 && bus.in_count <= 2'd2) else $error("illegal in_count %0d", bus.in_count);
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h want %0h", nm, act, exp);
  endtask
  task automatic chk_bundle(input string nm, input logic [1:0] v, input operation_t o0, input operation_t o1,
                            input logic [31:0] p0, input logic [31:0] p1);
    chk({nm, ".valid"}, 64'(bus.out_valid), 64'(v));
    chk({nm, ".op0"}, 64'(bus.out_operation[0]), 64'(o0));
    chk({nm, ".op1"}, 64'(bus.out_operation[1]), 64'(o1));
    chk({nm, ".pc0"}, 64'(bus.out_pc[31:0]), 64'(p0));
    chk({nm, ".pc1"}, 64'(bus.out_pc[63:32]), 64'(p1));
  endtask
  task automatic push(input logic [31:0] pc, input logic [31:0] i0, input logic [31:0] i1, input int cnt);
    bus.in_valid = 1'b1;
    bus.in_pc = pc;
    bus.in_inst = {i1, i0};
    bus.in_count = 2'(cnt);
    step();
    bus.in_valid = 1'b0;
  endtask
  task automatic do_flush();
    flush = 1'b1;
    step();
    flush = 1'b0;
  endtask
  initial begin
    vt[0]  = '{32'h1000, I_ADDU, I_ORI, 2, 2'b11, OP_ADDU, OP_ORI};
    vt[1]  = '{32'h1100, I_ADDU, I_BEQ, 2, 2'b01, OP_ADDU, OP_INVALID};
    vt[2]  = '{32'h1200, I_SYSCALL, I_ADDU, 2, 2'b01, OP_SYSCALL, OP_INVALID};
    vt[3]  = '{32'h1300, I_ADDU, I_ERET, 2, 2'b01, OP_ADDU, OP_INVALID};
    vt[4]  = '{32'h1400, I_JR, I_NOP, 2, 2'b11, OP_JR, OP_NOP};
    vt[5]  = '{32'h1500, I_LW, I_SW, 2, 2'b11, OP_LW, OP_SW};
    vt[6]  = '{32'h1600, I_MFC0, I_ADDU, 2, 2'b01, OP_MFC0, OP_INVALID};
    vt[7]  = '{32'h1700, I_BGEZAL, I_ADDIU, 2, 2'b11, OP_BGEZAL, OP_ADDIU};
    vt[8]  = '{32'h1800, I_BAD, I_LUI, 2, 2'b11, OP_INVALID, OP_LUI};
    vt[9]  = '{32'h1900, I_J, I_NOP, 1, 2'b00, OP_INVALID, OP_INVALID};
    vt[10] = '{32'h1A00, I_TLBP, I_ADDU, 2, 2'b01, OP_TLBP, OP_INVALID};
    vt[11] = '{32'h1B00, I_JAL, I_SUBU, 2, 2'b11, OP_JAL, OP_SUBU};
    vt[12] = '{32'h1C00, I_CACHE, I_LW, 2, 2'b01, OP_CACHE, OP_INVALID};
    bus.in_valid = 1'b0;
    bus.in_count = 2'd2;
    bus.in_pc = '0;
    bus.in_inst = '0;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b1;
    step();
    chk_bundle("reset", 2'b00, OP_INVALID, OP_INVALID, 32'h0, 32'h0);
    chk("reset.in_ready", 64'(bus.in_ready), 64'd1);
    bus.out_ready = 1'b1;
    for (int k = 0; k < NV; k++) begin
      push(vt[k].pc, vt[k].i0, vt[k].i1, vt[k].cnt);
      step();
      chk_bundle($sformatf("vec%0d", k), vt[k].v, vt[k].o0, vt[k].o1,
                 vt[k].v[0] ? vt[k].pc : 32'h0, vt[k].v[1] ? vt[k].pc + 32'd4 : 32'h0);
      chk($sformatf("vec%0d.inst0", k), 64'(bus.out_inst[31:0]), 64'(vt[k].v[0] ? vt[k].i0 : 32'h0));
      chk($sformatf("vec%0d.inst1", k), 64'(bus.out_inst[63:32]), 64'(vt[k].v[1] ? vt[k].i1 : 32'h0));
      do_flush();
    end
    push(32'h3000, I_ADDU, I_BEQ, 2);
    push(32'h3008, I_NOP, I_SW, 2);
    chk_bundle("br.b1", 2'b01, OP_ADDU, OP_INVALID, 32'h3000, 32'h0);
    step();
    chk_bundle("br.b2", 2'b11, OP_BEQ, OP_NOP, 32'h3004, 32'h3008);
    step();
    chk_bundle("br.b3", 2'b01, OP_SW, OP_INVALID, 32'h300C, 32'h0);
    do_flush();
    push(32'h4000, I_JR, I_NOP, 1);
    for (int c = 0; c < 3; c++) begin
      step();
      chk($sformatf("slotwait%0d.valid", c), 64'(bus.out_valid), 64'd0);
    end
    push(32'h4004, I_NOP, I_NOP, 1);
    step();
    chk_bundle("slot", 2'b11, OP_JR, OP_NOP, 32'h4000, 32'h4004);
    do_flush();
    push(32'h5000, I_SYSCALL, I_ADDU, 2);
    push(32'h5008, I_ERET, I_LW, 2);
    chk_bundle("ser.b1", 2'b01, OP_SYSCALL, OP_INVALID, 32'h5000, 32'h0);
    step();
    chk_bundle("ser.b2", 2'b01, OP_ADDU, OP_INVALID, 32'h5004, 32'h0);
    step();
    chk_bundle("ser.b3", 2'b01, OP_ERET, OP_INVALID, 32'h5008, 32'h0);
    step();
    chk_bundle("ser.b4", 2'b01, OP_LW, OP_INVALID, 32'h500C, 32'h0);
    step();
    chk("ser.empty", 64'(bus.out_valid), 64'd0);
    do_flush();
    bus.out_ready = 1'b0;
    beats = 0;
    while (bus.in_ready && beats < 10) begin
      push(32'h6000 + 32'(8 * beats), I_ADDIU | 32'(2 * beats), I_ADDIU | 32'(2 * beats + 1), 2);
      beats++;
    end
    chk("full.beats", 64'(beats), 64'd5);
    chk("full.in_ready", 64'(bus.in_ready), 64'd0);
    repeat (2) step();
    chk_bundle("full.hold", 2'b11, OP_ADDIU, OP_ADDIU, 32'h6000, 32'h6004);
    chk("full.hold.inst", 64'(bus.out_inst), {I_ADDIU | 32'd1, I_ADDIU});
    bus.out_ready = 1'b1;
    for (int b = 1; b < 5; b++) begin
      step();
      chk($sformatf("drain%0d.valid", b), 64'(bus.out_valid), 64'd3);
      chk($sformatf("drain%0d.inst", b), 64'(bus.out_inst), {I_ADDIU | 32'(2 * b + 1), I_ADDIU | 32'(2 * b)});
      chk($sformatf("drain%0d.pc0", b), 64'(bus.out_pc[31:0]), 64'(32'h6000 + 32'(8 * b)));
    end
    step();
    chk("drain.empty", 64'(bus.out_valid), 64'd0);
    bus.in_valid = 1'b1;
    bus.in_pc = 32'h7100;
    bus.in_inst = {I_ADDU, I_ADDU};
    bus.in_count = 2'd2;
    do_flush();
    bus.in_valid = 1'b0;
    step();
    chk("flushbeat.dropped", 64'(bus.out_valid), 64'd0);
    bus.out_ready = 1'b0;
    for (int b = 0; b < 5; b++) push(32'h6100 + 32'(8 * b), I_ADDU, I_ADDU, 2);
    chk("refill.in_ready", 64'(bus.in_ready), 64'd0);
    bus.in_valid = 1'b1;
    bus.in_pc = 32'h7000;
    do_flush();
    bus.in_valid = 1'b0;
    chk("flush.valid", 64'(bus.out_valid), 64'd0);
    chk("flush.in_ready", 64'(bus.in_ready), 64'd1);
    step();
    chk("flush.after", 64'(bus.out_valid), 64'd0);
    bus.out_ready = 1'b1;
    push(32'h2000, I_ADDU, I_ORI, 2);
    step();
    chk_bundle("postflush", 2'b11, OP_ADDU, OP_ORI, 32'h2000, 32'h2004);
    bus.out_ready = 1'b0;
    push(32'h8000, I_LW, I_SW, 2);
    push(32'h8008, I_LW, I_SW, 2);
    resetn = 1'b0;
    #1;
    chk_bundle("arst", 2'b00, OP_INVALID, OP_INVALID, 32'h0, 32'h0);
    chk("arst.in_ready", 64'(bus.in_ready), 64'd1);
    step();
    resetn = 1'b1;
    bus.out_ready = 1'b1;
    repeat (2) step();
    chk("arst.nobundle", 64'(bus.out_valid), 64'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
